// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master wb_gpio arbiter.
// State encoding and owner indices used by the arbiter FSM.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_WAIT = 2'd3
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog counter for the wb_gpio arbiter.
// Expires on the Nth consecutive unacknowledged strobed cycle.
module wb_arb_timeout #(
  parameter int cnt_width      = 8,
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int LIMI =
    (timeout_cycles == 0) ? 0 : timeout_cycles - 1;
  localparam logic [cnt_width-1:0] LIM = LIMI[cnt_width-1:0];
  localparam logic [cnt_width-1:0] ONE = cnt_width'(1);

  logic [cnt_width-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // the cycle that would bring the count to the limit is the last one
  assign o_expired = (timeout_cycles != 0) && i_inc && (r_cnt == LIM);

endmodule

// File: rtl/wb_gpio_arb.sv
// Round-robin, cyc-locked two-master arbiter in front of wb_gpio.
// A watchdog turns a never-acked access into an error to the owner.
module wb_gpio_arb
  import wb_arb_pkg::*;
#(
  parameter int wb_dat_width   = 32,
  parameter int wb_adr_width   = 32,
  parameter int timeout_cycles = 255,
  parameter int cnt_width      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [wb_adr_width-1:0] m0_adr_i,
  input  logic [wb_dat_width-1:0] m0_dat_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic [wb_dat_width-1:0] m0_dat_o,
  input  logic [wb_adr_width-1:0] m1_adr_i,
  input  logic [wb_dat_width-1:0] m1_dat_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [wb_dat_width-1:0] m1_dat_o,
  output logic [wb_adr_width-1:0] s_adr_o,
  output logic [wb_dat_width-1:0] s_dat_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic [wb_dat_width-1:0] s_dat_i,
  output logic [1:0]              gnt_o
);

  arb_state_t r_state, w_next;
  logic r_owner, w_owner_nxt;
  logic r_last, w_last_nxt;

  logic                    w_cyc, w_stb, w_we;
  logic [wb_adr_width-1:0] w_adr;
  logic [wb_dat_width-1:0] w_dat;
  logic w_busy, w_live, w_inc, w_clr, w_expired;

  assign w_cyc = (r_owner == M1) ? m1_cyc_i : m0_cyc_i;
  assign w_stb = (r_owner == M1) ? m1_stb_i : m0_stb_i;
  assign w_we  = (r_owner == M1) ? m1_we_i  : m0_we_i;
  assign w_adr = (r_owner == M1) ? m1_adr_i : m0_adr_i;
  assign w_dat = (r_owner == M1) ? m1_dat_i : m0_dat_i;

  assign w_busy = (r_state == ST_BUSY);
  assign w_live = w_busy && w_cyc;
  assign w_inc  = w_live && w_stb && !s_ack_i;
  assign w_clr  = !w_inc || (w_next != ST_BUSY);

  wb_arb_timeout #(
    .cnt_width      (cnt_width),
    .timeout_cycles (timeout_cycles)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst),
    .i_clr     (w_clr),
    .i_inc     (w_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= M0;
      r_last  <= M1;
    end else begin
      r_state <= w_next;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next      = ST_BUSY;
          w_owner_nxt = ~r_last;
        end else if (m0_cyc_i) begin
          w_next      = ST_BUSY;
          w_owner_nxt = M0;
        end else if (m1_cyc_i) begin
          w_next      = ST_BUSY;
          w_owner_nxt = M1;
        end
      end
      ST_BUSY: begin
        if (!w_cyc) begin
          w_next     = ST_IDLE;
          w_last_nxt = r_owner;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end
      ST_ERR: w_next = ST_WAIT;
      ST_WAIT: begin
        if (!w_cyc) begin
          w_next     = ST_IDLE;
          w_last_nxt = r_owner;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign s_cyc_o = w_live;
  assign s_stb_o = w_live && w_stb;
  assign s_we_o  = w_live && w_we;
  assign s_adr_o = w_live ? w_adr : '0;
  assign s_dat_o = w_live ? w_dat : '0;

  assign m0_ack_o = w_busy && (r_owner == M0) && s_ack_i;
  assign m1_ack_o = w_busy && (r_owner == M1) && s_ack_i;
  assign m0_err_o = (r_state == ST_ERR) && (r_owner == M0);
  assign m1_err_o = (r_state == ST_ERR) && (r_owner == M1);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign gnt_o = (r_state == ST_IDLE) ? 2'b00 :
                 (r_owner == M1)      ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_wb_gpio_arb.sv
// Self-checking bench for wb_gpio_arb: vector table, corner
// sequences, then random traffic against a behavioural model.
module tb_wb_gpio_arb;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd, s_adr, s_wd;
  logic        s_we, s_cyc, s_stb;
  logic [1:0]  gnt;

  always #5 clk = ~clk;

  wb_gpio_arb #(
    .wb_dat_width(32), .wb_adr_width(32),
    .timeout_cycles(T), .cnt_width(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err), .m0_dat_o(m0_rd),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err), .m1_dat_o(m1_rd),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack),
    .s_dat_i(s_dat), .gnt_o(gnt)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // {gnt[1:0], cyc, stb, we, ack0, ack1, err0, err1}
  function automatic logic [8:0] ctl();
    return {gnt, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // src: 0 slave lines idle, 1 muxed from m0, 2 muxed from m1
  task automatic chk_all(string nm, logic [8:0] ec, int src);
    chk({nm, ".ctl"}, {23'd0, ctl()}, {23'd0, ec});
    chk({nm, ".adr"}, s_adr,
        src == 1 ? m0_adr : src == 2 ? m1_adr : 32'd0);
    chk({nm, ".wdat"}, s_wd,
        src == 1 ? m0_dat : src == 2 ? m1_dat : 32'd0);
    chk({nm, ".rdat"}, m0_rd ^ m1_rd ^ m1_rd, s_dat);
  endtask

  task automatic hs(string nm, logic c0, logic s0, logic c1,
                    logic s1, logic w1, logic ack,
                    logic [8:0] ec, int src);
    m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
    m1_we = w1; s_ack = ack;
    #4;
    chk_all(nm, ec, src);
    tick();
  endtask

  typedef struct {
    logic c0, s0, c1, s1, w1, ack;
    logic [8:0] ec;
    int src;
  } vec_t;

  vec_t vt[24];

  // behavioural model: owner -1 means nobody holds the bus
  int mo, ml, mwt;
  bit me, mw;

  function automatic void mreset();
    mo = -1; ml = 1; mwt = 0; me = 0; mw = 0;
  endfunction

  function automatic logic gc(int i);
    return i == 1 ? m1_cyc : m0_cyc;
  endfunction

  function automatic logic gs(int i);
    return i == 1 ? m1_stb : m0_stb;
  endfunction

  function automatic void mupdate();
    if (mo < 0) begin
      if (gc(0) && gc(1)) mo = 1 - ml;
      else if (gc(0)) mo = 0;
      else if (gc(1)) mo = 1;
      mwt = 0;
    end else if (me) begin
      me = 0; mw = 1;
    end else if (mw) begin
      if (!gc(mo)) begin ml = mo; mo = -1; mw = 0; end
    end else if (!gc(mo)) begin
      ml = mo; mo = -1; mwt = 0;
    end else if (gs(mo) && !s_ack) begin
      if (mwt + 1 == T) begin me = 1; mwt = 0; end
      else mwt++;
    end else begin
      mwt = 0;
    end
  endfunction

  task automatic mcheck(int cyc);
    logic busy, live, wev;
    logic [8:0] ec;
    int src;
    busy = (mo >= 0) && !me && !mw;
    live = busy && gc(mo);
    wev  = (mo == 1) ? m1_we : m0_we;
    ec = '0;
    if (mo >= 0) ec[8:7] = (mo == 1) ? 2'b10 : 2'b01;
    ec[6] = live;
    ec[5] = live && gs(mo);
    ec[4] = live && wev;
    ec[3] = busy && mo == 0 && s_ack;
    ec[2] = busy && mo == 1 && s_ack;
    ec[1] = me && mo == 0;
    ec[0] = me && mo == 1;
    src = live ? mo + 1 : 0;
    chk_all($sformatf("rnd%0d", cyc), ec, src);
  endtask

  function automatic vec_t v(logic c0, logic s0, logic c1,
                             logic s1, logic w1, logic ack,
                             logic [8:0] ec, int src);
    vec_t r;
    r.c0 = c0; r.s0 = s0; r.c1 = c1; r.s1 = s1;
    r.w1 = w1; r.ack = ack; r.ec = ec; r.src = src;
    return r;
  endfunction

  initial begin
    rst = 1'b0;
    m0_adr = 32'h0; m0_dat = 32'h11; m0_we = 1'b0;
    m1_adr = 32'h4; m1_dat = 32'h3C; m1_we = 1'b0;
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    s_ack = 0; s_dat = 32'h0000_00A5;

    vt[0]  = v(0,0,0,0,0,0, 9'b00_000_00_00, 0);
    vt[1]  = v(1,1,1,1,0,0, 9'b00_000_00_00, 0);
    vt[2]  = v(1,1,1,1,0,0, 9'b01_110_00_00, 1);
    vt[3]  = v(1,1,1,1,0,1, 9'b01_110_10_00, 1);
    vt[4]  = v(0,0,1,1,0,0, 9'b01_000_00_00, 0);
    vt[5]  = v(0,0,1,1,1,1, 9'b00_000_00_00, 0);
    vt[6]  = v(1,1,1,1,1,0, 9'b10_111_00_00, 2);
    vt[7]  = v(1,1,1,1,1,1, 9'b10_111_01_00, 2);
    vt[8]  = v(1,1,0,0,0,0, 9'b10_000_00_00, 0);
    vt[9]  = v(1,1,1,1,0,0, 9'b00_000_00_00, 0);
    vt[10] = v(1,1,1,1,0,0, 9'b01_110_00_00, 1);
    vt[11] = v(0,0,1,1,0,0, 9'b01_000_00_00, 0);
    vt[12] = v(1,1,1,1,0,0, 9'b00_000_00_00, 0);
    vt[13] = v(1,1,1,1,0,0, 9'b10_110_00_00, 2);
    vt[14] = v(1,1,0,0,0,0, 9'b10_000_00_00, 0);
    vt[15] = v(1,1,0,0,0,0, 9'b00_000_00_00, 0);
    vt[16] = v(0,0,0,0,0,0, 9'b01_000_00_00, 0);
    vt[17] = v(0,0,0,0,0,1, 9'b00_000_00_00, 0);
    vt[18] = v(1,1,0,0,0,0, 9'b00_000_00_00, 0);
    vt[19] = v(1,1,0,0,0,0, 9'b01_110_00_00, 1);
    vt[20] = v(1,1,0,0,0,0, 9'b01_110_00_00, 1);
    vt[21] = v(1,1,0,0,0,1, 9'b01_110_10_00, 1);
    vt[22] = v(0,0,0,0,0,0, 9'b01_000_00_00, 0);
    vt[23] = v(0,0,0,0,0,0, 9'b00_000_00_00, 0);

    #3;
    chk_all("reset", 9'b0, 0);
    tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 24; i++)
      hs($sformatf("vec%0d", i), vt[i].c0, vt[i].s0, vt[i].c1,
         vt[i].s1, vt[i].w1, vt[i].ack, vt[i].ec, vt[i].src);

    // watchdog: four unacked strobes, then one error cycle
    hs("to_req", 1,1,0,0,0,0, 9'b00_000_00_00, 0);
    for (int i = 0; i < T; i++)
      hs($sformatf("to_wait%0d", i), 1,1,0,0,0,0,
         9'b01_110_00_00, 1);
    hs("to_err",   1,1,0,0,0,0, 9'b01_000_00_10, 0);
    hs("to_hold0", 1,1,0,0,0,0, 9'b01_000_00_00, 0);
    hs("to_hold1", 1,1,0,0,0,1, 9'b01_000_00_00, 0);
    hs("to_drop",  0,0,0,0,0,0, 9'b01_000_00_00, 0);
    hs("to_idle",  0,0,0,0,0,0, 9'b00_000_00_00, 0);

    // ack on the last permitted cycle beats the watchdog
    hs("al_req", 1,1,0,0,0,0, 9'b00_000_00_00, 0);
    for (int i = 0; i < T - 1; i++)
      hs($sformatf("al_wait%0d", i), 1,1,0,0,0,0,
         9'b01_110_00_00, 1);
    hs("al_ack",  1,1,0,0,0,1, 9'b01_110_10_00, 1);
    hs("al_more", 1,1,0,0,0,0, 9'b01_110_00_00, 1);
    hs("al_drop", 0,0,0,0,0,0, 9'b01_000_00_00, 0);
    hs("al_idle", 0,0,0,0,0,0, 9'b00_000_00_00, 0);

    // asynchronous reset in the middle of an m1 access
    hs("ar_req", 0,0,1,1,1,0, 9'b00_000_00_00, 0);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; s_ack = 0;
    #2;
    chk_all("ar_busy", 9'b10_111_00_00, 2);
    rst = 1'b0;
    #1;
    chk_all("ar_async", 9'b0, 0);
    tick();
    chk_all("ar_held", 9'b0, 0);
    rst = 1'b1;
    hs("ar_both", 1,1,1,1,0,0, 9'b00_000_00_00, 0);
    hs("ar_m0",   1,1,1,1,0,0, 9'b01_110_00_00, 1);
    hs("ar_rel",  0,0,0,0,0,0, 9'b01_000_00_00, 0);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    mreset();
    m0_cyc = 0; m1_cyc = 0;
    for (int c = 0; c < 400; c++) begin
      if (m0_cyc) m0_cyc = ($urandom_range(99) < 85);
      else        m0_cyc = ($urandom_range(99) < 35);
      if (m1_cyc) m1_cyc = ($urandom_range(99) < 85);
      else        m1_cyc = ($urandom_range(99) < 35);
      m0_stb = ($urandom_range(99) < 75);
      m1_stb = ($urandom_range(99) < 75);
      m0_we  = 1'($urandom);
      m1_we  = 1'($urandom);
      m0_adr = $urandom; m0_dat = $urandom;
      m1_adr = $urandom; m1_dat = $urandom;
      s_dat  = $urandom;
      s_ack  = ($urandom_range(99) < 25);
      #4;
      mcheck(c);
      tick();
      mupdate();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
